// File: rtl/reg_file_sb.sv
// 2-write / 2-read register file with a pending-write scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle writes to the read ports.
module reg_file_sb #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    output logic              rd_busy1,
    output logic              rd_busy2,
    input  logic              wr_en0,
    input  logic              wr_en1,
    input  logic [ADDR_W-1:0] wr_addr0,
    input  logic [ADDR_W-1:0] wr_addr1,
    input  logic [DATA_W-1:0] wr_data0,
    input  logic [DATA_W-1:0] wr_data1,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_addr,
    output logic [ADDR_W:0]   busy_cnt,
    output logic              rsv_err
);

    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;
    logic [NUM_REGS-1:0] clr_mask;
    logic [NUM_REGS-1:0] set_mask;
    logic [ADDR_W:0]     cnt_q;
    logic [ADDR_W:0]     cnt_d;
    logic                err_q;
    logic                err_d;
    logic                we0;
    logic                we1;
    logic                rs;
    logic                inc;
    logic                clr0;
    logic                clr1;
    logic                dup;

    assign we0 = wr_en0 && (wr_addr0 != '0);
    assign we1 = wr_en1 && (wr_addr1 != '0);
    assign rs  = rsv_en && (rsv_addr != '0);

    always_comb begin
        clr_mask = '0;
        set_mask = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            clr_mask[i] = (we0 && wr_addr0 == ADDR_W'(i))
                       || (we1 && wr_addr1 == ADDR_W'(i));
            set_mask[i] = rs && rsv_addr == ADDR_W'(i);
        end
        busy_d = (busy_q & ~clr_mask) | set_mask;
    end

    // A write clears a busy bit only if it was set and no reserve re-sets it.
    always_comb begin
        dup   = we0 && we1 && (wr_addr0 == wr_addr1);
        inc   = rs && !busy_q[rsv_addr];
        clr0  = we0 && busy_q[wr_addr0]
             && !(rs && rsv_addr == wr_addr0);
        clr1  = we1 && busy_q[wr_addr1]
             && !(rs && rsv_addr == wr_addr1) && !dup;
        cnt_d = cnt_q + {{ADDR_W{1'b0}}, inc}
              - {{ADDR_W{1'b0}}, clr0}
              - {{ADDR_W{1'b0}}, clr1};
        err_d = err_q
             | (rs && busy_q[rsv_addr] && !clr_mask[rsv_addr]);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q <= '0;
            cnt_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            err_q  <= err_d;
        end
    end

    // Port 1 is written last so it wins on an address collision.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (we0) begin
                regs[wr_addr0] <= wr_data0;
            end
            if (we1) begin
                regs[wr_addr1] <= wr_data1;
            end
        end
    end

    always_comb begin
        rd_data1 = '0;
        rd_busy1 = 1'b0;
        if (rd_addr1 != '0) begin
            rd_data1 = regs[rd_addr1];
            rd_busy1 = busy_q[rd_addr1];
`ifdef REGFILE_BYPASS_EN
            if (we1 && wr_addr1 == rd_addr1) begin
                rd_data1 = wr_data1;
                rd_busy1 = rs && rsv_addr == rd_addr1;
            end else if (we0 && wr_addr0 == rd_addr1) begin
                rd_data1 = wr_data0;
                rd_busy1 = rs && rsv_addr == rd_addr1;
            end
`endif
        end
    end

    always_comb begin
        rd_data2 = '0;
        rd_busy2 = 1'b0;
        if (rd_addr2 != '0) begin
            rd_data2 = regs[rd_addr2];
            rd_busy2 = busy_q[rd_addr2];
`ifdef REGFILE_BYPASS_EN
            if (we1 && wr_addr1 == rd_addr2) begin
                rd_data2 = wr_data1;
                rd_busy2 = rs && rsv_addr == rd_addr2;
            end else if (we0 && wr_addr0 == rd_addr2) begin
                rd_data2 = wr_data0;
                rd_busy2 = rs && rsv_addr == rd_addr2;
            end
`endif
        end
    end

    assign busy_cnt = cnt_q;
    assign rsv_err  = err_q;

endmodule

// File: tb/tb_reg_file_sb.sv
// Scoreboard bench for reg_file_sb: a behavioural model pushes expected
// read/status values, which are popped against DUT outputs.
module tb_reg_file_sb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  rd_addr1, rd_addr2;
    logic [31:0] rd_data1, rd_data2;
    logic        rd_busy1, rd_busy2;
    logic        wr_en0, wr_en1;
    logic [4:0]  wr_addr0, wr_addr1;
    logic [31:0] wr_data0, wr_data1;
    logic        rsv_en;
    logic [4:0]  rsv_addr;
    logic [5:0]  busy_cnt;
    logic        rsv_err;

    reg_file_sb dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_addr1 (rd_addr1),
        .rd_addr2 (rd_addr2),
        .rd_data1 (rd_data1),
        .rd_data2 (rd_data2),
        .rd_busy1 (rd_busy1),
        .rd_busy2 (rd_busy2),
        .wr_en0   (wr_en0),
        .wr_en1   (wr_en1),
        .wr_addr0 (wr_addr0),
        .wr_addr1 (wr_addr1),
        .wr_data0 (wr_data0),
        .wr_data1 (wr_data1),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr),
        .busy_cnt (busy_cnt),
        .rsv_err  (rsv_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t        sb_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;

    logic [31:0] m_regs [32];
    logic [31:0] m_busy;
    logic        m_err;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic push(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb_q.push_back(e);
    endtask

    task automatic pop_chk(input logic [31:0] got);
        exp_t e;
        if (sb_q.size() == 0) begin
            chk("sb_empty", got, 32'hxxxx_xxxx);
        end else begin
            e = sb_q.pop_front();
            chk(e.tag, got, e.val);
        end
    endtask

    function automatic int m_cnt();
        int c = 0;
        for (int i = 1; i < 32; i++) c += int'(m_busy[i]);
        return c;
    endfunction

    function automatic void exp_rd(input logic [4:0] a,
                                   output logic [31:0] d,
                                   output logic b);
        d = 32'h0;
        b = 1'b0;
        if (a != 0) begin
            d = m_regs[a];
            b = m_busy[a];
`ifdef REGFILE_BYPASS_EN
            if (wr_en1 && wr_addr1 == a) begin
                d = wr_data1;
                b = rsv_en && rsv_addr == a;
            end else if (wr_en0 && wr_addr0 == a) begin
                d = wr_data0;
                b = rsv_en && rsv_addr == a;
            end
`endif
        end
    endfunction

    function automatic void model_edge();
        logic [31:0] nb;
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
            m_busy = 32'h0;
            m_err  = 1'b0;
            return;
        end
        nb = m_busy;
        if (wr_en0 && wr_addr0 != 0) begin
            m_regs[wr_addr0] = wr_data0;
            nb[wr_addr0] = 1'b0;
        end
        if (wr_en1 && wr_addr1 != 0) begin
            m_regs[wr_addr1] = wr_data1;
            nb[wr_addr1] = 1'b0;
        end
        if (rsv_en && rsv_addr != 0) begin
            if (nb[rsv_addr]) m_err = 1'b1;
            nb[rsv_addr] = 1'b1;
        end
        m_busy = nb;
    endfunction

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        wr_en0 = 0; wr_en1 = 0; rsv_en = 0;
        wr_addr0 = 0; wr_addr1 = 0; rsv_addr = 0;
        wr_data0 = 0; wr_data1 = 0;
    endtask

    task automatic rd_check(input logic [4:0] a1, input logic [4:0] a2);
        logic [31:0] d;
        logic        b;
        rd_addr1 = a1;
        rd_addr2 = a2;
        exp_rd(a1, d, b);
        push($sformatf("rd_data1[%0d]", a1), d);
        push($sformatf("rd_busy1[%0d]", a1), {31'b0, b});
        exp_rd(a2, d, b);
        push($sformatf("rd_data2[%0d]", a2), d);
        push($sformatf("rd_busy2[%0d]", a2), {31'b0, b});
        #1;
        pop_chk(rd_data1);
        pop_chk({31'b0, rd_busy1});
        pop_chk(rd_data2);
        pop_chk({31'b0, rd_busy2});
    endtask

    task automatic st_check();
        push("busy_cnt", 32'(m_cnt()));
        push("rsv_err", {31'b0, m_err});
        pop_chk(32'(busy_cnt));
        pop_chk({31'b0, rsv_err});
    endtask

    initial begin
        #200000;
        $display("FAIL timeout got running exp finished");
        $fatal(1, "timeout");
    end

    initial begin
        m_busy = 32'h0;
        m_err  = 1'b0;
        for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
        rst_n = 0;
        rd_addr1 = 0;
        rd_addr2 = 0;
        idle();
        step();
        step();
        rst_n = 1;
        for (int i = 0; i < 32; i++) rd_check(5'(i), 5'(31 - i));
        st_check();

        wr_en0 = 1; wr_addr0 = 5; wr_data0 = 32'hDEADBEEF;
        wr_en1 = 1; wr_addr1 = 5; wr_data1 = 32'h12345678;
        step();
        idle();
        rd_check(5, 0);
        wr_en0 = 1; wr_addr0 = 0; wr_data0 = 32'hFFFFFFFF;
        step();
        idle();
        rd_check(0, 5);

        rsv_en = 1; rsv_addr = 7;
        step();
        idle();
        rd_check(7, 6);
        st_check();
        wr_en1 = 1; wr_addr1 = 7; wr_data1 = 32'hA5;
        step();
        idle();
        rd_check(7, 7);
        st_check();

        rsv_en = 1; rsv_addr = 9;
        step();
        st_check();
        step();
        idle();
        st_check();
        step();
        st_check();
        rsv_en = 1; rsv_addr = 9;
        wr_en0 = 1; wr_addr0 = 9; wr_data0 = 32'h99;
        step();
        idle();
        rd_check(9, 0);
        st_check();

        wr_en0 = 1; wr_addr0 = 3; wr_data0 = 32'h55;
        rd_check(3, 0);
        step();
        idle();
        rd_check(3, 3);
        rsv_en = 1; rsv_addr = 12;
        wr_en1 = 1; wr_addr1 = 12; wr_data1 = 32'hC0FFEE;
        rd_check(12, 3);
        step();
        idle();
        rd_check(12, 0);
        st_check();

        rsv_en = 1; rsv_addr = 4;
        step();
        rsv_addr = 6;
        step();
        idle();
        st_check();
        rst_n = 0;
        wr_en0 = 1; wr_addr0 = 4; wr_data0 = 32'h44;
        rsv_en = 1; rsv_addr = 8;
        step();
        rst_n = 1;
        idle();
        rd_check(4, 6);
        rd_check(8, 5);
        st_check();

        for (int n = 0; n < 400; n++) begin
            wr_en0   = 1'($urandom_range(0, 1));
            wr_en1   = 1'($urandom_range(0, 1));
            wr_addr0 = 5'($urandom_range(0, 7));
            wr_addr1 = 5'($urandom_range(0, 7));
            wr_data0 = $urandom;
            wr_data1 = $urandom;
            rsv_en   = ($urandom_range(0, 2) == 0);
            rsv_addr = 5'($urandom_range(0, 7));
            rd_check(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            step();
            st_check();
        end
        idle();
        for (int i = 0; i < 8; i++) rd_check(5'(i), 5'(7 - i));
        if (sb_q.size() != 0) chk("sb_left", 32'(sb_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/reg_file_sb.md
# reg_file_sb

Parametrised 2-write / 2-read integer register file with an integrated pending-write scoreboard, succeeding the single-write-port register file in the core datapath. It sits between decode (reads, destination reservation) and the two writeback paths (ALU and load/store), and reports per-operand busy status so the issue stage can stall on unresolved hazards. Register 0 is hardwired to zero and can never be written, reserved, or busy.

## Interface
- DATA_W, 32, register width in bits
- NUM_REGS, 32, number of registers; power of two, at least 2
- ADDR_W, $clog2(NUM_REGS), address width (derived; do not override)

- clk  input  1  single clock; all state updates on rising edge
- rst_n  input  1  reset, synchronous, active-low
- rd_addr1, rd_addr2  input  ADDR_W  read port addresses
- rd_data1, rd_data2  output  DATA_W  read data (combinational)
- rd_busy1, rd_busy2  output  1  addressed register has a pending write (combinational)
- wr_en0, wr_en1  input  1  write enables; port 0 = ALU writeback, port 1 = LSU writeback
- wr_addr0, wr_addr1  input  ADDR_W  write addresses
- wr_data0, wr_data1  input  DATA_W  write data
- rsv_en  input  1  reserve destination register (mark busy)
- rsv_addr  input  ADDR_W  register to reserve
- busy_cnt  output  ADDR_W+1  number of currently busy registers (registered)
- rsv_err  output  1  sticky: reserve issued to an already-busy register (registered)

## Operation
- Storage: NUM_REGS x DATA_W array plus NUM_REGS busy bits; entry 0 excluded from both.
- Reset (rst_n low at a rising edge): all registers 0, all busy bits 0, busy_cnt 0, rsv_err 0. Combinational outputs therefore read 0 / not-busy after reset.
- Write: wr_enN with wr_addrN != 0 stores wr_dataN and clears that busy bit. Writes to address 0 are ignored.
- Same-address dual write: port 1 wins data; busy bit cleared once.
- Reserve: rsv_en with rsv_addr != 0 sets the busy bit. If that bit is already set (after considering same-cycle clears), rsv_err sets and stays set until reset.
- Reserve and write same address same cycle: reserve wins; bit ends set (new producer), no rsv_err.
- Read: address 0 returns 0 and busy 0; otherwise the stored value and busy bit (bypass rules below).
- busy_cnt: next = current + (reserve sets a previously clear bit) - (number of distinct bits cleared by writes and not re-set by reserve). Never underflows: writes to non-busy registers do not decrement.

## Timing
- Read latency 0 (combinational from rd_addr and state).
- Write/reserve effects visible on reads the cycle after the edge (without bypass).
- busy_cnt and rsv_err update one edge after the causing event.
- rst_n asserted mid-activity overrides all same-cycle writes and reserves.

## Configuration
- REGFILE_BYPASS_EN defined: a read whose address matches an active same-cycle write (nonzero addr) returns that write's data (port 1 over port 0) and reports busy 0, unless a same-cycle reserve targets it, in which case busy is 1 but data is still forwarded.
- Undefined: reads return only stored state; same-cycle writes are visible next cycle.

## Test plan
- Reset then read addrs 0..31 -> all rd_data 0, rd_busy 0, busy_cnt 0, rsv_err 0.
- wr_en0 addr 5 data 0xDEADBEEF and wr_en1 addr 5 data 0x12345678 same cycle; read 5 next cycle -> 0x12345678; write 0xFFFFFFFF to addr 0 -> addr 0 still reads 0.
- Reserve 7 -> next cycle rd_busy(7)=1, busy_cnt=1; write 7 = 0xA5 via port 1 -> next cycle busy 0, busy_cnt 0, data 0xA5.
- Reserve 9 twice on consecutive cycles -> rsv_err=1 after second edge, remains 1; busy_cnt=1; reserve 9 plus write 9 same cycle -> busy stays 1, no extra error beyond sticky.
- With REGFILE_BYPASS_EN: write 3 = 0x55 while reading 3 same cycle -> rd_data 0x55, busy 0; without macro -> old value 0.
- Reserve 4, 6 then assert rst_n low for one edge alongside write 4 -> all busy 0, busy_cnt 0, reg 4 reads 0.
